// File: rtl/perf_display.sv
// Selects one of four 32-bit performance counters, converts it to BCD with a
// sequential shift-add-3 engine and scans it onto an 8-digit seven-segment display.
module perf_display #(
  parameter int SCAN_DIV    = 1000,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        in_CLK,
  input  logic        in_RST,
  input  logic [31:0] in_total,
  input  logic [31:0] in_J,
  input  logic [31:0] in_JS,
  input  logic [31:0] in_loaduse,
  input  logic [1:0]  in_SEL,
  output logic [7:0]  out_AN,
  output logic [7:0]  out_SEG,
  output logic        out_BUSY
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] REF_TC  = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_pend;
  logic [1:0]  r_sel_q;
  logic [RW-1:0] r_ref;
  logic [31:0] r_shift;
  logic [39:0] r_bcd, w_adj;
  logic [4:0]  r_cnt;
  logic [31:0] r_dig;
  logic        r_ovf;
  logic [SW-1:0] r_div;
  logic [2:0]  r_idx;
  logic [7:0]  r_an, r_seg;
  logic        w_ref_tick, w_req, w_take, w_blank, w_dp;
  logic [31:0] w_sel_val;
  logic [3:0]  w_cur;
  logic [6:0]  w_seg7;

  assign w_ref_tick = (r_ref == REF_TC);
  assign w_req      = w_ref_tick | (in_SEL != r_sel_q);
  assign w_take     = (r_state == S_IDLE) && r_pend;
  // Busy covers the whole CONV run plus the DONE commit cycle.
  assign out_BUSY   = (r_state != S_IDLE);
  assign out_AN     = r_an;
  assign out_SEG    = r_seg;

  always_ff @(posedge in_CLK) begin
    if (in_RST) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pend) w_next = S_CONV;
      S_CONV:  if (r_cnt == 5'd31) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_val = in_total;
    case (in_SEL)
      2'd0: w_sel_val = in_total;
      2'd1: w_sel_val = in_J;
      2'd2: w_sel_val = in_JS;
      2'd3: w_sel_val = in_loaduse;
      default: w_sel_val = in_total;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < 10; k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end

  // Requests arriving while busy collapse into the single pending flag.
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_pend  <= 1'b1;
      r_sel_q <= in_SEL;
      r_ref   <= '0;
    end else begin
      r_pend  <= w_req | (r_pend & ~w_take);
      r_sel_q <= in_SEL;
      r_ref   <= w_ref_tick ? '0 : r_ref + 1'b1;
    end
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_dig   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (r_pend) begin
          r_shift <= w_sel_val;
          r_bcd   <= '0;
          r_cnt   <= '0;
        end
        S_CONV: begin
          r_bcd   <= {w_adj[38:0], r_shift[31]};
          r_shift <= {r_shift[30:0], 1'b0};
          r_cnt   <= r_cnt + 5'd1;
        end
        S_DONE: begin
          r_dig <= r_bcd[31:0];
          r_ovf <= |r_bcd[39:32];
        end
        default: ;
      endcase
    end
  end

  assign w_cur   = r_dig[{r_idx, 2'b00} +: 4];
  assign w_dp    = r_ovf && (r_idx == 3'd7);
  // A digit is blank when it and every digit above it are zero.
  assign w_blank = BLANK_LZ && !r_ovf && (r_idx != 3'd0) &&
                   ((r_dig >> {r_idx, 2'b00}) == 32'd0);

  always_comb begin
    w_seg7 = 7'h7F;
    case (w_cur)
      4'h0: w_seg7 = 7'h40;  4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;  4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;  4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;  4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;  4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = 7'h08;  4'hB: w_seg7 = 7'h03;
      4'hC: w_seg7 = 7'h46;  4'hD: w_seg7 = 7'h21;
      4'hE: w_seg7 = 7'h06;  4'hF: w_seg7 = 7'h0E;
      default: w_seg7 = 7'h7F;
    endcase
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_div <= '0;
      r_idx <= 3'd0;
      r_an  <= 8'hFE;
      r_seg <= 8'hC0;
    end else begin
      if (r_div == SCAN_TC) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_blank ? 8'hFF : {~w_dp, w_seg7};
    end
  end
endmodule

// File: tb/tb_perf_display.sv
// Directed bench for perf_display: busy timing, scanned digit contents,
// blanking, overflow dp, mid-conversion reselect and reset abort.
module tb_perf_display;
  logic        clk = 1'b0;
  logic        in_RST;
  logic [31:0] in_total, in_J, in_JS, in_loaduse;
  logic [1:0]  in_SEL;
  logic [7:0]  out_AN, out_SEG, an2, seg2;
  logic        out_BUSY, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  perf_display #(.SCAN_DIV(4), .REFRESH_DIV(300), .BLANK_LZ(1'b1)) dut (
    .in_CLK(clk), .in_RST(in_RST), .in_total(in_total), .in_J(in_J),
    .in_JS(in_JS), .in_loaduse(in_loaduse), .in_SEL(in_SEL),
    .out_AN(out_AN), .out_SEG(out_SEG), .out_BUSY(out_BUSY));

  perf_display #(.SCAN_DIV(4), .REFRESH_DIV(300), .BLANK_LZ(1'b0)) dut2 (
    .in_CLK(clk), .in_RST(in_RST), .in_total(in_total), .in_J(in_J),
    .in_JS(in_JS), .in_loaduse(in_loaduse), .in_SEL(in_SEL),
    .out_AN(an2), .out_SEG(seg2), .out_BUSY(busy2));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_tab(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {AN, SEG} for digit i of value v.
  function automatic logic [15:0] model(input longint unsigned v, input int i, input bit blz);
    longint unsigned low, p;
    bit ovf;
    int d;
    logic [7:0] s, an, one;
    ovf = (v > 64'd99999999);
    low = v % 64'd100000000;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    d = int'((low / p) % 10);
    s = {!(ovf && i == 7), seg_tab(d)};
    if (blz && !ovf && i > 0 && low < p) s = 8'hFF;
    one = 8'b1;
    an = ~(one << i);
    return {an, s};
  endfunction

  task automatic check_scan(input bit which, input longint unsigned v, input bit blz);
    logic [15:0] e;
    logic [7:0] an, sg;
    bit found;
    for (int i = 0; i < 8; i++) exp_q.push_back(model(v, i, blz));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      found = 1'b0;
      for (int t = 0; t < 40 && !found; t++) begin
        an = which ? an2 : out_AN;
        if (an == e[15:8]) found = 1'b1;
        else @(negedge clk);
      end
      sg = which ? seg2 : out_SEG;
      chk("scan_an_found", 32'(found), 32'd1);
      if (found) chk("scan_seg", {24'd0, sg}, {24'd0, e[7:0]});
    end
  endtask

  // j counts rising edges since reset was released.
  task automatic busy_window(input int lo, input int hi, input int last);
    for (int j = 0; j <= last; j++) begin
      chk("busy_window", 32'(out_BUSY), 32'((j >= lo && j <= hi) ? 1 : 0));
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_an", {24'd0, out_AN}, 32'hFE);
    chk("rst_seg", {24'd0, out_SEG}, 32'hC0);
    chk("rst_busy", 32'(out_BUSY), 32'd0);
  endtask

  initial begin
    bit seen0;
    in_RST = 1'b1; in_SEL = 2'd0;
    in_total = 32'd12345678; in_J = 32'd0; in_JS = 32'd0; in_loaduse = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_state();

    in_RST = 1'b0;
    busy_window(1, 33, 34);
    check_scan(0, 64'd12345678, 1'b1);

    // Reselect mid-conversion: first result committed, second follows at once.
    in_RST = 1'b1; in_total = 32'd5; in_JS = 32'd42;
    @(negedge clk);
    in_RST = 1'b0;
    seen0 = 1'b0;
    for (int j = 0; j <= 68; j++) begin
      chk("mid_busy", 32'(out_BUSY), 32'(((j >= 1 && j <= 33) || (j >= 35 && j <= 67)) ? 1 : 0));
      if (j >= 35 && !seen0 && out_AN == 8'hFE) begin
        seen0 = 1'b1;
        chk("mid_first_digit0", {24'd0, out_SEG}, 32'h92);
      end
      if (j == 10) in_SEL = 2'd2;
      @(negedge clk);
    end
    chk("mid_first_seen", 32'(seen0), 32'd1);
    check_scan(0, 64'd42, 1'b1);

    // Reset during CONV aborts and restarts the conversion.
    in_loaduse = 32'd9; in_SEL = 2'd3;
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", 32'(out_BUSY), 32'd1);
    in_RST = 1'b1;
    @(negedge clk);
    check_reset_state();
    in_RST = 1'b0;
    busy_window(1, 33, 34);
    check_scan(0, 64'd9, 1'b1);

    in_total = 32'd4294967295; in_SEL = 2'd0;
    repeat (80) @(negedge clk);
    check_scan(0, 64'd4294967295, 1'b1);

    in_J = 32'd100000000; in_SEL = 2'd1;
    repeat (80) @(negedge clk);
    check_scan(0, 64'd100000000, 1'b1);

    in_JS = 32'd0; in_SEL = 2'd2;
    repeat (80) @(negedge clk);
    check_scan(0, 64'd0, 1'b1);

    in_loaduse = 32'd7; in_SEL = 2'd3;
    repeat (80) @(negedge clk);
    check_scan(1, 64'd7, 1'b0);
    check_scan(0, 64'd7, 1'b1);

    // Same select, new value: only the refresh tick can pick it up.
    in_loaduse = 32'd123;
    repeat (400) @(negedge clk);
    check_scan(0, 64'd123, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
